// File: rtl/flash_audio_pkg.sv
// Shared flash/audio constants and the address-generator state type.
// Also imported by the flash reader stage.
package flash_audio_pkg;

  localparam int FLASH_WORD_AW = 21;

  localparam logic [FLASH_WORD_AW-1:0] AUDIO_START = 21'h000000;
  localparam logic [FLASH_WORD_AW-1:0] AUDIO_END   = 21'h07FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } addr_state_t;

endpackage

// File: rtl/bounded_step.sv
// Combinational one-word step inside [i_lo, i_hi] with wrap detection.
// Bounds are compared on the current address, so no carry bit is needed.
module bounded_step #(
  parameter int ADDR_W = 21
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_up,
  input  logic              i_down,
  input  logic [ADDR_W-1:0] i_lo,
  input  logic [ADDR_W-1:0] i_hi,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_wrap
);

  // NOTE: every output gets a default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    o_next = i_addr;
    o_wrap = 1'b0;
    if (i_up && !i_down) begin
      if (i_addr == i_hi) begin
        o_next = i_lo;
        o_wrap = 1'b1;
      end else begin
        o_next = i_addr + ADDR_W'(1);
      end
    end else if (i_down && !i_up) begin
      if (i_addr == i_lo) begin
        o_next = i_hi;
        o_wrap = 1'b1;
      end else begin
        o_next = i_addr - ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_addr_ctrl.sv
// Flash word-address generator: steps through the audio region on reader
// inc/dec pulses, wrapping (LOOP=1) or latching done at the far end (LOOP=0).
module flash_addr_ctrl
  import flash_audio_pkg::*;
#(
  parameter int                ADDR_W     = FLASH_WORD_AW,
  parameter logic [ADDR_W-1:0] START_ADDR = AUDIO_START,
  parameter logic [ADDR_W-1:0] END_ADDR   = AUDIO_END,
  parameter int                LOOP       = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inc,
  input  logic              dec,
  input  logic              addr_reset,
  input  logic              play,
  input  logic              reverse,
  input  logic              restart,
  output logic [ADDR_W-1:0] address,
  output logic              wrapped,
  output logic              done
);

  localparam bit STOP_AT_END = (LOOP == 0);

  addr_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic              r_wrapped, w_wrapped_nxt;
  logic              r_done, w_done_nxt;

  logic              w_restart;
  logic [ADDR_W-1:0] w_sp;
  logic              w_step_en, w_up, w_down;
  logic [ADDR_W-1:0] w_step_addr;
  logic              w_step_wrap;
  logic              w_stop_hit, w_fwd_stop;

  assign w_restart = addr_reset | restart;
  assign w_sp      = reverse ? END_ADDR : START_ADDR;

  // Simultaneous inc and dec cancel out, hence the XOR.
  assign w_step_en = play & (inc ^ dec) & (r_state == ST_RUN);
  assign w_up      = w_step_en &  (inc ^ reverse);
  assign w_down    = w_step_en & ~(inc ^ reverse);

  bounded_step #(
    .ADDR_W (ADDR_W)
  ) u_step (
    .i_addr (r_address),
    .i_up   (w_up),
    .i_down (w_down),
    .i_lo   (START_ADDR),
    .i_hi   (END_ADDR),
    .o_next (w_step_addr),
    .o_wrap (w_step_wrap)
  );

  // Without looping any wrap is blocked; only an inc past EP ends playback.
  assign w_stop_hit = STOP_AT_END & w_step_wrap;
  assign w_fwd_stop = w_stop_hit & inc;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_address <= START_ADDR;
      r_wrapped <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_address <= w_address_nxt;
      r_wrapped <= w_wrapped_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = ST_RUN;
    end else if (w_fwd_stop) begin
      w_state_nxt = ST_DONE;
    end
  end

  always_comb begin
    w_address_nxt = r_address;
    w_wrapped_nxt = 1'b0;
    w_done_nxt    = (w_state_nxt == ST_DONE);
    if (w_restart) begin
      w_address_nxt = w_sp;
    end else if (!w_stop_hit) begin
      w_address_nxt = w_step_addr;
      w_wrapped_nxt = w_step_wrap;
    end
  end

  assign address = r_address;
  assign wrapped = r_wrapped;
  assign done    = r_done;

endmodule

// File: tb/tb_flash_addr_ctrl.sv
// Bench for flash_addr_ctrl over an 8-word region, one looping and one
// stopping instance, against an integer-arithmetic reference model.
module tb_flash_addr_ctrl;

  localparam int AW = 21;
  localparam int S  = 0;
  localparam int E  = 7;

  logic clk = 1'b0;
  logic reset_n, inc, dec, addr_reset, play, reverse, restart;
  logic [AW-1:0] l_address, s_address;
  logic l_wrapped, s_wrapped, l_done, s_done;

  int total = 0;
  int bad   = 0;

  int m_addr [2];
  bit m_wrap [2];
  bit m_done [2];
  bit m_valid = 1'b0;

  always #5 clk = ~clk;

  flash_addr_ctrl #(.ADDR_W(AW), .START_ADDR(21'd0), .END_ADDR(21'd7), .LOOP(1)) dut_loop (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .addr_reset(addr_reset),
    .play(play), .reverse(reverse), .restart(restart),
    .address(l_address), .wrapped(l_wrapped), .done(l_done)
  );

  flash_addr_ctrl #(.ADDR_W(AW), .START_ADDR(21'd0), .END_ADDR(21'd7), .LOOP(0)) dut_stop (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec), .addr_reset(addr_reset),
    .play(play), .reverse(reverse), .restart(restart),
    .address(s_address), .wrapped(s_wrapped), .done(s_done)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model; index 0 loops, index 1 stops at the far end.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      int dir;
      int tgt;
      m_wrap[l] = 1'b0;
      if (!reset_n) begin
        m_addr[l] = S;
        m_done[l] = 1'b0;
      end else if (addr_reset || restart) begin
        m_addr[l] = reverse ? E : S;
        m_done[l] = 1'b0;
      end else if (play && !m_done[l] && (inc != dec)) begin
        dir = inc ? 1 : -1;
        if (reverse) dir = -dir;
        tgt = m_addr[l] + dir;
        if (tgt > E || tgt < S) begin
          if (l == 0) begin
            m_addr[l] = (tgt > E) ? S : E;
            m_wrap[l] = 1'b1;
          end else if (inc) begin
            m_done[l] = 1'b1;
          end
        end else begin
          m_addr[l] = tgt;
        end
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("loop_addr", int'(l_address), m_addr[0]);
      check("loop_wrap", int'(l_wrapped), int'(m_wrap[0]));
      check("loop_done", int'(l_done),    int'(m_done[0]));
      check("stop_addr", int'(s_address), m_addr[1]);
      check("stop_wrap", int'(s_wrapped), int'(m_wrap[1]));
      check("stop_done", int'(s_done),    int'(m_done[1]));
    end
  end

  task automatic step(input logic i, input logic d, input logic a, input logic r);
    inc = i; dec = d; addr_reset = a; restart = r;
    @(posedge clk);
    #2;
    inc = 1'b0; dec = 1'b0; addr_reset = 1'b0; restart = 1'b0;
  endtask

  task automatic expect4(input string tag, input int la, input int lw, input int sa, input int sd);
    check({tag, "_loop_addr"}, int'(l_address), la);
    check({tag, "_loop_wrap"}, int'(l_wrapped), lw);
    check({tag, "_stop_addr"}, int'(s_address), sa);
    check({tag, "_stop_done"}, int'(s_done),    sd);
  endtask

  initial begin
    reset_n = 1'b0; inc = 1'b0; dec = 1'b0; addr_reset = 1'b0;
    play = 1'b0; reverse = 1'b0; restart = 1'b0;
    @(posedge clk);
    #2;

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    expect4("reset", 0, 0, 0, 0);
    reset_n = 1'b1;
    play    = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      check("pre_edge_addr", int'(l_address), k - 1);
      step(1, 0, 0, 0);
      expect4("count", k, 0, k, 0);
    end

    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    expect4("at_end", 7, 0, 7, 0);
    step(1, 0, 0, 0);
    expect4("wrap_fwd", 0, 1, 7, 1);
    step(0, 0, 0, 0);
    expect4("wrap_gone", 0, 0, 7, 1);
    reverse = 1'b1;
    step(1, 0, 0, 0);
    expect4("wrap_rev", 7, 1, 7, 1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    expect4("done_hold", 7, 0, 7, 1);
    reverse = 1'b0;
    step(0, 0, 0, 1);
    expect4("restart", 0, 0, 0, 0);

    play = 1'b0;
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
    expect4("paused", 0, 0, 0, 0);
    play = 1'b1;
    step(1, 1, 0, 0);
    expect4("inc_dec", 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) step(1, 0, 0, 0);
    expect4("at5", 5, 0, 5, 0);
    reverse = 1'b1;
    step(1, 0, 1, 0);
    expect4("areset_rev", 7, 0, 7, 0);
    reset_n = 1'b0;
    step(0, 0, 0, 0);
    expect4("mid_reset", 0, 0, 0, 0);
    reset_n = 1'b1;

    reverse = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    expect4("dec_fwd", 2, 0, 2, 0);
    reverse = 1'b1;
    step(0, 1, 0, 0);
    expect4("dec_rev", 3, 0, 3, 0);
    reverse = 1'b0;
    step(0, 0, 0, 0);
    expect4("toggle", 3, 0, 3, 0);

    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    expect4("dec_at_sp", 7, 1, 0, 0);
    reverse = 1'b1;
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    expect4("dec_at_sp_rev", 0, 1, 7, 0);

    for (int n = 0; n < 2000; n++) begin
      reset_n    = ($urandom_range(0, 199) != 0);
      play       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) reverse = ~reverse;
      inc        = 1'($urandom_range(0, 1));
      dec        = ($urandom_range(0, 3) == 0);
      addr_reset = ($urandom_range(0, 39) == 0);
      restart    = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
